// File: rtl/ofifo_drain_pkg.sv
// Shared types and constants for the OFIFO drain controller and its lane ALU.
package ofifo_drain_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      ACC,
      WR,
      FIN
   } state_e;

   localparam int unsigned COL_DEF     = 8;
   localparam int unsigned PSUM_BW_DEF = 16;
   localparam int unsigned ADDR_BW_DEF = 11;

   localparam int PSUM_MAX = (1 <<< (PSUM_BW_DEF - 1)) - 1;
   localparam int PSUM_MIN = -(1 <<< (PSUM_BW_DEF - 1));

endpackage

// File: rtl/psum_lane_alu.sv
// One psum lane: saturating signed accumulate, and ReLU on the value being written.
module psum_lane_alu
   import ofifo_drain_pkg::*;
#(
   parameter int unsigned psum_bw = PSUM_BW_DEF
) (
   input  logic [psum_bw-1:0] fifo_lane_i,
   input  logic [psum_bw-1:0] sram_lane_i,
   input  logic [psum_bw-1:0] wr_lane_i,
   input  logic               relu_en_i,
   output logic [psum_bw-1:0] sum_o,
   output logic [psum_bw-1:0] wr_o
);

   logic [psum_bw:0] sum_x;

   always_comb begin
      sum_x = {fifo_lane_i[psum_bw-1], fifo_lane_i} + {sram_lane_i[psum_bw-1], sram_lane_i};
      // Differing top two bits of the widened sum mean the result left the lane range.
      if (sum_x[psum_bw] != sum_x[psum_bw-1]) begin
         sum_o = sum_x[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      end else begin
         sum_o = sum_x[psum_bw-1:0];
      end
      wr_o = (relu_en_i && wr_lane_i[psum_bw-1]) ? '0 : wr_lane_i;
   end

endmodule

// File: rtl/ofifo_drain.sv
// OFIFO read-side controller: pops rows, optionally accumulates with stored psums,
// optionally applies ReLU, and writes each row to the psum SRAM at base_addr+row.
module ofifo_drain
   import ofifo_drain_pkg::*;
#(
   parameter int unsigned col     = COL_DEF,
   parameter int unsigned psum_bw = PSUM_BW_DEF,
   parameter int unsigned addr_bw = ADDR_BW_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [addr_bw-1:0]       base_addr,
   input  logic [addr_bw-1:0]       num_rows,
   input  logic                     acc_en,
   input  logic                     relu_en,
   input  logic                     fifo_empty,
   output logic                     fifo_rd,
   input  logic [col*psum_bw-1:0]   fifo_out,
   output logic                     sram_cen,
   output logic                     sram_wen,
   output logic [addr_bw-1:0]       sram_addr,
   output logic [col*psum_bw-1:0]   sram_d,
   input  logic [col*psum_bw-1:0]   sram_q,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned W = col * psum_bw;

   state_e             state_q, state_d;
   logic [addr_bw-1:0] base_q, base_d, nrows_q, nrows_d, row_q, row_d, addr_q, addr_d;
   logic               acc_en_q, acc_en_d, relu_en_q, relu_en_d;
   logic [W-1:0]       sum_q, sum_d, data_q, data_d;
   logic               fifo_rd_q, fifo_rd_d, cen_q, cen_d, wen_q, wen_d;
   logic               busy_q, busy_d, done_q, done_d;

   logic [W-1:0]       lane_sum, wr_src, wr_data;
   logic [addr_bw-1:0] row_addr, row_nxt;

   assign wr_src   = acc_en_q ? sum_q : fifo_out;
   assign row_addr = base_q + row_q;
   assign row_nxt  = row_q + addr_bw'(1);

   for (genvar i = 0; i < col; i++) begin : g_lane
      psum_lane_alu #(.psum_bw(psum_bw)) u_alu (
         .fifo_lane_i (fifo_out[i*psum_bw +: psum_bw]),
         .sram_lane_i (sram_q[i*psum_bw +: psum_bw]),
         .wr_lane_i   (wr_src[i*psum_bw +: psum_bw]),
         .relu_en_i   (relu_en_q),
         .sum_o       (lane_sum[i*psum_bw +: psum_bw]),
         .wr_o        (wr_data[i*psum_bw +: psum_bw])
      );
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      nrows_d   = nrows_q;
      row_d     = row_q;
      acc_en_d  = acc_en_q;
      relu_en_d = relu_en_q;
      sum_d     = sum_q;
      data_d    = data_q;
      addr_d    = addr_q;
      fifo_rd_d = 1'b0;
      cen_d     = 1'b1;
      wen_d     = 1'b1;
      busy_d    = busy_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               base_d    = base_addr;
               nrows_d   = num_rows;
               acc_en_d  = acc_en;
               relu_en_d = relu_en;
               row_d     = '0;
               busy_d    = 1'b1;
               state_d   = (num_rows == '0) ? FIN : POP;
            end
         end
         // POP spends one cycle issuing the read and one while the pop is visible.
         POP: begin
            if (fifo_rd_q) begin
               state_d = acc_en_q ? ACC : WR;
            end else if (!fifo_empty) begin
               fifo_rd_d = 1'b1;
               if (acc_en_q) begin
                  cen_d  = 1'b0;
                  addr_d = row_addr;
               end
            end
         end
         ACC: begin
            sum_d   = lane_sum;
            state_d = WR;
         end
         WR: begin
            cen_d   = 1'b0;
            wen_d   = 1'b0;
            addr_d  = row_addr;
            data_d  = wr_data;
            row_d   = row_nxt;
            state_d = (row_nxt == nrows_q) ? FIN : POP;
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         base_q    <= '0;
         nrows_q   <= '0;
         row_q     <= '0;
         acc_en_q  <= 1'b0;
         relu_en_q <= 1'b0;
         sum_q     <= '0;
         data_q    <= '0;
         addr_q    <= '0;
         fifo_rd_q <= 1'b0;
         cen_q     <= 1'b1;
         wen_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         nrows_q   <= nrows_d;
         row_q     <= row_d;
         acc_en_q  <= acc_en_d;
         relu_en_q <= relu_en_d;
         sum_q     <= sum_d;
         data_q    <= data_d;
         addr_q    <= addr_d;
         fifo_rd_q <= fifo_rd_d;
         cen_q     <= cen_d;
         wen_q     <= wen_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign fifo_rd   = fifo_rd_q;
   assign sram_cen  = cen_q;
   assign sram_wen  = wen_q;
   assign sram_addr = addr_q;
   assign sram_d    = data_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
